// File: rtl/issue_unit.sv
// Warp issue unit: round-robin issue and exit arbitration over active warps,
// with per-warp active flags and a running count of issue grants.
module issue_unit #(
  parameter int NUM_WARPS    = 8,
  parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WARPS-1:0]    req_IB_IU,
  input  logic [NUM_WARPS-1:0]    exit_req_IB_IU,
  input  logic                    full_OC_IU,
  input  logic                    Launch_Valid_TM_IU,
  input  logic [LOGNUM_WARPS-1:0] Launch_WarpID_TM_IU,
  output logic [NUM_WARPS-1:0]    grt_IU_IB,
  output logic [NUM_WARPS-1:0]    exit_grt_IU_IB,
  output logic [NUM_WARPS-1:0]    active_mask_IU,
  output logic [31:0]             issue_cnt_IU
);

  localparam int unsigned NW = NUM_WARPS;

  logic [NUM_WARPS-1:0]    active_mask;
  logic [LOGNUM_WARPS-1:0] issue_ptr, exit_ptr;
  logic [LOGNUM_WARPS-1:0] issue_idx, exit_idx;
  logic [LOGNUM_WARPS-1:0] issue_ptr_next, exit_ptr_next;
  logic [31:0]             issue_cnt;
  logic [NUM_WARPS-1:0]    issue_elig, exit_elig, launch_vec;

  // First eligible warp at or above ptr, wrapping past the top index.
  function automatic logic [NUM_WARPS-1:0] rr_pick(
    input logic [NUM_WARPS-1:0]    elig,
    input logic [LOGNUM_WARPS-1:0] ptr
  );
    logic [NUM_WARPS-1:0] g;
    logic                 found;
    int unsigned          idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NW; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NW) idx = idx - NW;
      if (!found && elig[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [LOGNUM_WARPS-1:0] onehot_idx(input logic [NUM_WARPS-1:0] v);
    logic [LOGNUM_WARPS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (v[i]) r = i[LOGNUM_WARPS-1:0];
    end
    return r;
  endfunction

  always_comb begin
    exit_elig  = exit_req_IB_IU & active_mask;
    issue_elig = full_OC_IU ? '0 : (req_IB_IU & active_mask & ~exit_req_IB_IU);
    grt_IU_IB      = rst ? '0 : rr_pick(issue_elig, issue_ptr);
    exit_grt_IU_IB = rst ? '0 : rr_pick(exit_elig, exit_ptr);
    issue_idx = onehot_idx(grt_IU_IB);
    exit_idx  = onehot_idx(exit_grt_IU_IB);
    issue_ptr_next = (32'(issue_idx) == NW - 1) ? '0 : issue_idx + 1'b1;
    exit_ptr_next  = (32'(exit_idx)  == NW - 1) ? '0 : exit_idx + 1'b1;
    launch_vec = '0;
    if (Launch_Valid_TM_IU) launch_vec[Launch_WarpID_TM_IU] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_mask <= '0;
      issue_ptr   <= '0;
      exit_ptr    <= '0;
      issue_cnt   <= '0;
    end else begin
      // Launch is applied after the exit clear so a coinciding launch wins.
      active_mask <= (active_mask & ~exit_grt_IU_IB) | launch_vec;
      if (|grt_IU_IB) begin
        issue_ptr <= issue_ptr_next;
        issue_cnt <= issue_cnt + 32'd1;
      end
      if (|exit_grt_IU_IB) exit_ptr <= exit_ptr_next;
    end
  end

  assign active_mask_IU = active_mask;
  assign issue_cnt_IU   = issue_cnt;

endmodule
